// File: rtl/present_pkg.sv
// Shared constants, S-box tables and FSM state type for the PRESENT-80 key schedule.
package present_pkg;

   localparam int KEY_W    = 80;
   localparam int RK_W     = 64;
   localparam int ROUNDS   = 31;
   localparam int NUM_KEYS = 32;
   localparam int CTR_W    = 5;
   localparam int IDX_W    = 6;

   localparam logic [CTR_W-1:0] LAST_CTR  = CTR_W'(ROUNDS);
   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(NUM_KEYS);

   localparam logic [3:0] SBOX [16] = '{
      4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
   };

   localparam logic [3:0] INV_SBOX [16] = '{
      4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
      4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FWD,
      ST_EMIT
   } state_t;

endpackage

// File: rtl/key_schedule.sv
// Forward PRESENT-80 key-register update: rotate left 61, S-box top nibble, xor round counter.
module key_schedule
   import present_pkg::*;
(
   input  logic [KEY_W-1:0] x,
   input  logic [CTR_W-1:0] i,
   output logic [KEY_W-1:0] r
);

   logic [KEY_W-1:0] rot;

   always_comb begin
      rot       = {x[18:0], x[79:19]};
      r         = rot;
      r[79:76]  = SBOX[rot[79:76]];
      r[19:15]  = rot[19:15] ^ i;
   end

endmodule

// File: rtl/key_schedule_inv.sv
// Inverse PRESENT-80 key-register update; undoes key_schedule for the same counter value.
module key_schedule_inv
   import present_pkg::*;
(
   input  logic [KEY_W-1:0] x,
   input  logic [CTR_W-1:0] i,
   output logic [KEY_W-1:0] r
);

   logic [KEY_W-1:0] t;

   always_comb begin
      t         = x;
      t[19:15]  = x[19:15] ^ i;
      t[79:76]  = INV_SBOX[x[79:76]];
      r         = {t[60:0], t[79:61]};
   end

endmodule

// File: rtl/key_schedule_rev.sv
// Reverse-order PRESENT-80 round-key streamer (K32..K1) over valid/ready.
// Optional final-state cache enabled by defining KEY_SCHEDULE_REV_REUSE_EN.
module key_schedule_rev
   import present_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [KEY_W-1:0] x,
   output logic             busy,
   output logic [RK_W-1:0]  k,
   output logic [IDX_W-1:0] k_idx,
   output logic             k_valid,
   input  logic             k_ready,
   output logic             done
);

   state_t           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic [IDX_W-1:0] k_idx_q, k_idx_d;
   logic [RK_W-1:0]  k_q, k_d;
   logic             busy_q, busy_d;
   logic             k_valid_q, k_valid_d;
   logic             done_q, done_d;

   logic [KEY_W-1:0] f_out, g_out;
   logic [CTR_W-1:0] g_i;

`ifdef KEY_SCHEDULE_REV_REUSE_EN
   logic [KEY_W-1:0] mkey_q, mkey_d;
   logic [KEY_W-1:0] cache_key_q, cache_key_d;
   logic [KEY_W-1:0] cache_reg_q, cache_reg_d;
   logic             cache_vld_q, cache_vld_d;
   logic             cache_hit;
`endif

   // Low five bits of k_idx minus one give k_idx-1 for 32 as well (0-1 wraps to 31).
   assign g_i = k_idx_q[CTR_W-1:0] - CTR_W'(1);

   key_schedule     u_fwd (.x(key_q), .i(ctr_q), .r(f_out));
   key_schedule_inv u_inv (.x(key_q), .i(g_i),   .r(g_out));

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      ctr_d   = ctr_q;
      k_idx_d = k_idx_q;
      done_d  = 1'b0;
`ifdef KEY_SCHEDULE_REV_REUSE_EN
      mkey_d      = mkey_q;
      cache_key_d = cache_key_q;
      cache_reg_d = cache_reg_q;
      cache_vld_d = cache_vld_q;
      cache_hit   = cache_vld_q && (x == cache_key_q);
`endif

      case (state_q)
         ST_IDLE: begin
            if (req) begin
`ifdef KEY_SCHEDULE_REV_REUSE_EN
               if (cache_hit) begin
                  key_d   = cache_reg_q;
                  ctr_d   = '0;
                  k_idx_d = FIRST_IDX;
                  state_d = ST_EMIT;
               end else begin
                  key_d   = x;
                  mkey_d  = x;
                  ctr_d   = CTR_W'(1);
                  state_d = ST_FWD;
               end
`else
               key_d   = x;
               ctr_d   = CTR_W'(1);
               state_d = ST_FWD;
`endif
            end
         end
         ST_FWD: begin
            key_d = f_out;
            if (ctr_q == LAST_CTR) begin
               ctr_d   = '0;
               k_idx_d = FIRST_IDX;
               state_d = ST_EMIT;
`ifdef KEY_SCHEDULE_REV_REUSE_EN
               cache_key_d = mkey_q;
               cache_reg_d = f_out;
               cache_vld_d = 1'b1;
`endif
            end else begin
               ctr_d = ctr_q + CTR_W'(1);
            end
         end
         ST_EMIT: begin
            if (k_ready) begin
               if (k_idx_q == IDX_W'(1)) begin
                  k_idx_d = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  key_d   = g_out;
                  k_idx_d = k_idx_q - IDX_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d    = (state_d != ST_IDLE);
      k_valid_d = (state_d == ST_EMIT);
      k_d       = k_valid_d ? key_d[KEY_W-1:KEY_W-RK_W] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         key_q     <= '0;
         ctr_q     <= '0;
         k_idx_q   <= '0;
         k_q       <= '0;
         busy_q    <= 1'b0;
         k_valid_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef KEY_SCHEDULE_REV_REUSE_EN
         mkey_q      <= '0;
         cache_key_q <= '0;
         cache_reg_q <= '0;
         cache_vld_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         ctr_q     <= ctr_d;
         k_idx_q   <= k_idx_d;
         k_q       <= k_d;
         busy_q    <= busy_d;
         k_valid_q <= k_valid_d;
         done_q    <= done_d;
`ifdef KEY_SCHEDULE_REV_REUSE_EN
         mkey_q      <= mkey_d;
         cache_key_q <= cache_key_d;
         cache_reg_q <= cache_reg_d;
         cache_vld_q <= cache_vld_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign k       = k_q;
   assign k_idx   = k_idx_q;
   assign k_valid = k_valid_q;
   assign done    = done_q;

endmodule
